key4x4_scan: RTL and testbench

Scanning input driver for a 4x4 matrix keypad, the input-side counterpart of the board's multiplexed seven-segment display driver. It drives one keypad row low at a time and samples the four column lines. It assembles a 16-key snapshot per sweep and debounces whole snapshots. When a stable snapshot holding exactly one key appears, it emits that key's 4-bit code with a one-cycle valid strobe. The code feeds the counter/control logic, which can pass it on to the display driver's 4-bit `data_in`.

---
 rtl/key4x4_scan.sv | 114 +++++++++++
 tb/tb_key4x4_scan.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/key4x4_scan.sv
// rtl/key4x4_scan.sv - 4x4 matrix keypad row scanner with snapshot debounce
//
// Drives one keypad row low at a time and samples the column lines on the
// last clock of each row dwell. One sweep covers all four rows and builds a
// 16-key snapshot. A snapshot is accepted once it has repeated for DEBOUNCE
// further sweeps and differs from the last accepted one. An accepted
// snapshot holding exactly one key strobes that key's code.
//
// Ports:
//   clk       system clock
//   rst       synchronous active-high reset
//   col[3:0]  column lines, active-low, already synchronised
//   row[3:0]  row drive, active-low, exactly one row low
//   key_code  code of the last accepted single key (row*4 + col)
//   key_valid one-cycle strobe marking a new key_code
//   key_down  high while the accepted snapshot has any key pressed
module key4x4_scan #(
    parameter int SCAN_DIV = 10000,
    parameter int DEBOUNCE = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] col,
    output logic [3:0] row,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int SW = $clog2(DEBOUNCE + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE);

    logic [DW-1:0] div_cnt;
    logic [1:0]    r;
    logic [15:0]   cur;
    logic [15:0]   prev;
    logic [15:0]   acc;
    logic [SW-1:0] stable;

    logic          tick;
    logic          sweep_end;
    logic [15:0]   snap;
    logic [SW-1:0] stable_nxt;
    logic          accept;
    logic          single;
    logic [3:0]    snap_idx;

    assign tick      = (div_cnt == DIV_LAST);
    assign sweep_end = tick && (r == 2'd3);
    assign row       = ~(4'b0001 << r);

    always_comb begin
        // The row-3 nibble is still being sampled this cycle, so splice it in.
        snap        = cur;
        snap[15:12] = ~col;

        stable_nxt = '0;
        if (snap == prev) begin
            stable_nxt = (stable == STABLE_MAX) ? stable : stable + 1'b1;
        end

        // Repeated sweeps at saturation keep re-qualifying, but the
        // snap != acc term makes a held snapshot accept only once.
        accept = sweep_end && (stable_nxt == STABLE_MAX) && (snap != acc);

        single = (snap != 16'd0) && ((snap & (snap - 16'd1)) == 16'd0);

        snap_idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (snap[i]) begin
                snap_idx = 4'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt   <= '0;
            r         <= 2'd0;
            cur       <= 16'd0;
            prev      <= 16'd0;
            acc       <= 16'd0;
            stable    <= '0;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            key_down  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            div_cnt   <= tick ? '0 : div_cnt + 1'b1;

            if (tick) begin
                cur[{r, 2'b00} +: 4] <= ~col;
                r                    <= r + 2'd1;
            end

            if (sweep_end) begin
                stable <= stable_nxt;
                prev   <= snap;
            end

            if (accept) begin
                acc      <= snap;
                key_down <= (snap != 16'd0);
                if (single) begin
                    key_valid <= 1'b1;
                    key_code  <= snap_idx;
                end
            end
        end
    end

endmodule

// File: tb/tb_key4x4_scan.sv
// tb/tb_key4x4_scan.sv - self-checking bench for key4x4_scan against a sweep-history model
module tb_key4x4_scan;

    localparam int SD    = 4;
    localparam int DB    = 2;
    localparam int SWEEP = 4 * SD;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  col;
    logic [3:0]  row;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_down;
    logic [15:0] pressed;

    always #5 clk = ~clk;

    key4x4_scan #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
        .clk       (clk),
        .rst       (rst),
        .col       (col),
        .row       (row),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_down  (key_down)
    );

    // Physical keypad: a pressed key shorts its column to any driven row.
    always_comb begin
        col = 4'hF;
        for (int rr = 0; rr < 4; rr++) begin
            for (int c = 0; c < 4; c++) begin
                if (!row[rr] && pressed[rr*4+c]) begin
                    col[c] = 1'b0;
                end
            end
        end
    end

    // Reference model: cycle index since reset, the per-sweep snapshot and a
    // history of recent snapshots (seeded with the all-clear reset snapshot).
    int          m_t;
    logic [15:0] m_snap;
    logic [15:0] m_acc;
    logic [15:0] m_hist[$];
    logic        m_kv;
    logic        m_kd;
    logic [3:0]  m_kc;

    int n_checks = 0;
    int n_pass   = 0;
    int strobes  = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    function automatic bit hist_settled();
        if (m_hist.size() != DB + 1) return 1'b0;
        foreach (m_hist[i]) if (m_hist[i] != m_hist[0]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_edge();
        if (rst) begin
            m_t    = 0;
            m_snap = 16'd0;
            m_acc  = 16'd0;
            m_kv   = 1'b0;
            m_kd   = 1'b0;
            m_kc   = 4'd0;
            m_hist.delete();
            m_hist.push_back(16'd0);
        end else begin
            m_kv = 1'b0;
            if (m_t % SD == SD - 1) begin
                int ri;
                ri = (m_t / SD) % 4;
                m_snap[ri*4 +: 4] = pressed[ri*4 +: 4];
                if (ri == 3) begin
                    m_hist.push_back(m_snap);
                    if (m_hist.size() > DB + 1) void'(m_hist.pop_front());
                    if (hist_settled() && m_snap != m_acc) begin
                        m_acc = m_snap;
                        m_kd  = (m_snap != 16'd0);
                        if ($countones(m_snap) == 1) begin
                            m_kv = 1'b1;
                            for (int i = 0; i < 16; i++) if (m_snap[i]) m_kc = 4'(i);
                        end
                    end
                end
            end
            m_t++;
        end
    endtask

    task automatic step();
        logic [3:0] row_exp;
        @(posedge clk);
        model_edge();
        #1;
        row_exp = ~(4'b0001 << ((m_t / SD) % 4));
        check("row", 16'(row), 16'(row_exp));
        check("key_valid", 16'(key_valid), 16'(m_kv));
        check("key_code", 16'(key_code), 16'(m_kc));
        check("key_down", 16'(key_down), 16'(m_kd));
        if (key_valid) strobes++;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic align();
        while (m_t % SWEEP != 0) step();
    endtask

    initial begin
        rst     = 1'b1;
        pressed = 16'd0;

        // Reset and idle row stepping.
        run(3);
        rst = 1'b0;
        check("rst_row", 16'(row), 16'h000E);
        check("rst_code", 16'(key_code), 16'd0);
        check("rst_valid", 16'(key_valid), 16'd0);
        check("rst_down", 16'(key_down), 16'd0);
        run(SWEEP);

        // Single press of key 9, held.
        align();
        strobes = 0;
        pressed = 16'd1 << 9;
        run(3 * SWEEP - 1);
        check("press_early", 16'(strobes), 16'd0);
        run(1);
        check("press_strobe", 16'(strobes), 16'd1);
        check("press_code", 16'(key_code), 16'd9);
        check("press_down", 16'(key_down), 16'd1);
        run(2 * SWEEP);
        check("press_held", 16'(strobes), 16'd1);

        // Release.
        strobes = 0;
        pressed = 16'd0;
        run(3 * SWEEP - 1);
        check("rel_down_early", 16'(key_down), 16'd1);
        run(1);
        check("rel_down", 16'(key_down), 16'd0);
        check("rel_strobe", 16'(strobes), 16'd0);

        // Bounce on key 0, then hold.
        align();
        strobes = 0;
        for (int i = 0; i < 10; i++) begin
            pressed = pressed ^ 16'd1;
            run(10);
        end
        check("bounce_quiet", 16'(strobes), 16'd0);
        pressed = 16'd1;
        run(4 * SWEEP);
        check("bounce_strobe", 16'(strobes), 16'd1);
        check("bounce_code", 16'(key_code), 16'd0);

        // Two keys: 5, then 5+15, then back to 5.
        pressed = 16'd0;
        run(4 * SWEEP);
        align();
        strobes = 0;
        pressed = 16'd1 << 5;
        run(4 * SWEEP);
        check("two_first", 16'(strobes), 16'd1);
        check("two_first_code", 16'(key_code), 16'd5);
        pressed = pressed | (16'd1 << 15);
        run(4 * SWEEP);
        check("two_both", 16'(strobes), 16'd1);
        check("two_both_code", 16'(key_code), 16'd5);
        pressed = 16'd1 << 5;
        run(4 * SWEEP);
        check("two_back", 16'(strobes), 16'd2);
        check("two_back_code", 16'(key_code), 16'd5);

        // Reset in the middle of the second sweep with key 3 held.
        pressed = 16'd0;
        run(4 * SWEEP);
        align();
        strobes = 0;
        pressed = 16'd1 << 3;
        run(SWEEP + 6);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_quiet", 16'(strobes), 16'd0);
        run(3 * SWEEP - 1);
        check("mid_rst_early", 16'(strobes), 16'd0);
        run(1);
        check("mid_rst_strobe", 16'(strobes), 16'd1);
        check("mid_rst_code", 16'(key_code), 16'd3);

        // Reset landing exactly on the accept edge.
        pressed = 16'd0;
        run(4 * SWEEP);
        align();
        strobes = 0;
        pressed = 16'd1 << 6;
        run(3 * SWEEP - 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("acc_rst_strobe", 16'(strobes), 16'd0);
        check("acc_rst_down", 16'(key_down), 16'd0);
        run(3 * SWEEP);
        check("acc_rst_again", 16'(strobes), 16'd1);
        check("acc_rst_code", 16'(key_code), 16'd6);

        // Randomised phases: idle, single keys, chords, chatter, resets.
        for (int ph = 0; ph < 50; ph++) begin
            int kind;
            int len;
            kind = $urandom_range(0, 9);
            len  = $urandom_range(8, 120);
            if (kind <= 2) pressed = 16'd0;
            else if (kind <= 6) pressed = 16'd1 << $urandom_range(0, 15);
            else if (kind <= 8) pressed = (16'd1 << $urandom_range(0, 15)) | (16'd1 << $urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
            end
            for (int c = 0; c < len; c++) begin
                if (kind == 9 && $urandom_range(0, 3) == 0) pressed = pressed ^ (16'd1 << $urandom_range(0, 15));
                step();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
